// File: rtl/dds_sweep_pkg.sv
// Shared widths and FSM state encoding for the DDS sweep sequencer.
package dds_sweep_pkg;

  localparam int FW_DEF = 32;
  localparam int PW_DEF = 12;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    STEP  = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_next.sv
// Next sweep frequency: cur +/- step in FW+1 bits, clamped to stop on carry/borrow or overshoot.
// Purely combinational, no backpressure.
module dds_sweep_next
  import dds_sweep_pkg::*;
#(
  parameter int FW = FW_DEF
) (
  input  logic [FW-1:0] cur,
  input  logic [FW-1:0] step,
  input  logic [FW-1:0] stop,
  input  logic          dir_dn,
  output logic [FW-1:0] nxt,
  output logic          at_stop
);

  logic [FW:0] w_sum;
  logic [FW:0] w_dif;
  logic        w_clamp;

  always_comb begin
    w_sum = {1'b0, cur} + {1'b0, step};
    w_dif = {1'b0, cur} - {1'b0, step};
    // The extra top bit is the carry (up) or borrow (down); either means we ran past stop.
    if (dir_dn) begin
      w_clamp = w_dif[FW] || (w_dif[FW-1:0] <= stop);
    end else begin
      w_clamp = w_sum[FW] || (w_sum[FW-1:0] >= stop);
    end
    if (w_clamp) begin
      nxt = stop;
    end else if (dir_dn) begin
      nxt = w_dif[FW-1:0];
    end else begin
      nxt = w_sum[FW-1:0];
    end
    at_stop = w_clamp;
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear Fword sweep sequencer feeding the dds core; each frequency held max(dwell,1)+1 cycles.
// Config accepted only in IDLE (cfg_ready); abort wins over everything. Optional: DDS_SWEEP_PHASE_STEP_EN.
module dds_sweep_ctrl
  import dds_sweep_pkg::*;
#(
  parameter int FW = FW_DEF,
  parameter int PW = PW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [FW-1:0] cfg_f_start,
  input  logic [FW-1:0] cfg_f_stop,
  input  logic [FW-1:0] cfg_f_step,
  input  logic [DW-1:0] cfg_dwell,
  input  logic [PW-1:0] cfg_pword,
  input  logic          cfg_cont,
`ifdef DDS_SWEEP_PHASE_STEP_EN
  input  logic [PW-1:0] cfg_p_step,
`endif
  input  logic          start,
  input  logic          abort,
  output logic [FW-1:0] Fword,
  output logic [PW-1:0] Pword,
  output logic          busy,
  output logic          step_strobe,
  output logic          sweep_done
);

  localparam logic [DW-1:0] DW_ONE = {{(DW-1){1'b0}}, 1'b1};

  function automatic logic [DW-1:0] dwell_cnt(input logic [DW-1:0] d);
    return (d == '0) ? '0 : (d - DW_ONE);
  endfunction

  logic [FW-1:0] r_f_start;
  logic [FW-1:0] r_f_stop;
  logic [FW-1:0] r_f_step;
  logic [DW-1:0] r_dwell;
  logic [PW-1:0] r_cfg_pword;
  logic          r_cont;
  logic          r_dir_dn;
`ifdef DDS_SWEEP_PHASE_STEP_EN
  logic [PW-1:0] r_p_step;
`endif

  sweep_state_t  r_state;
  logic [FW-1:0] r_fword;
  logic [PW-1:0] r_pword;
  logic          r_busy;
  logic          r_strobe;
  logic          r_done;
  logic [DW-1:0] r_cnt;

  sweep_state_t  w_state_nxt;
  logic [FW-1:0] w_fword_nxt;
  logic [PW-1:0] w_pword_nxt;
  logic          w_busy_nxt;
  logic          w_strobe_nxt;
  logic          w_done_nxt;
  logic [DW-1:0] w_cnt_nxt;

  logic          w_cfg_rdy;
  logic          w_cfg_acc;
  logic [FW-1:0] w_ld_f_start;
  logic [DW-1:0] w_ld_dwell;
  logic [PW-1:0] w_ld_pword;
  logic [PW-1:0] w_pword_step;
  logic [FW-1:0] w_nxt;
  logic          w_at_stop;

  assign w_cfg_rdy = (r_state == IDLE);
  assign w_cfg_acc = cfg_valid && w_cfg_rdy;

  // A start arriving with a config uses the incoming fields, not the stale latched ones.
  assign w_ld_f_start = w_cfg_acc ? cfg_f_start : r_f_start;
  assign w_ld_dwell   = w_cfg_acc ? cfg_dwell   : r_dwell;
  assign w_ld_pword   = w_cfg_acc ? cfg_pword   : r_cfg_pword;

`ifdef DDS_SWEEP_PHASE_STEP_EN
  assign w_pword_step = r_pword + r_p_step;
`else
  assign w_pword_step = r_pword;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_f_start   <= '0;
      r_f_stop    <= '0;
      r_f_step    <= '0;
      r_dwell     <= '0;
      r_cfg_pword <= '0;
      r_cont      <= 1'b0;
      r_dir_dn    <= 1'b0;
`ifdef DDS_SWEEP_PHASE_STEP_EN
      r_p_step    <= '0;
`endif
    end else if (w_cfg_acc) begin
      r_f_start   <= cfg_f_start;
      r_f_stop    <= cfg_f_stop;
      r_f_step    <= cfg_f_step;
      r_dwell     <= cfg_dwell;
      r_cfg_pword <= cfg_pword;
      r_cont      <= cfg_cont;
      r_dir_dn    <= (cfg_f_start > cfg_f_stop);
`ifdef DDS_SWEEP_PHASE_STEP_EN
      r_p_step    <= cfg_p_step;
`endif
    end
  end

  dds_sweep_next #(
    .FW (FW)
  ) u_next (
    .cur     (r_fword),
    .step    (r_f_step),
    .stop    (r_f_stop),
    .dir_dn  (r_dir_dn),
    .nxt     (w_nxt),
    .at_stop (w_at_stop)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_fword_nxt  = r_fword;
    w_pword_nxt  = r_pword;
    w_busy_nxt   = r_busy;
    w_strobe_nxt = 1'b0;
    w_done_nxt   = 1'b0;
    w_cnt_nxt    = r_cnt;
    if (abort) begin
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_state_nxt  = DWELL;
            w_fword_nxt  = w_ld_f_start;
            w_pword_nxt  = w_ld_pword;
            w_busy_nxt   = 1'b1;
            w_strobe_nxt = 1'b1;
            w_cnt_nxt    = dwell_cnt(w_ld_dwell);
          end
        end
        DWELL: begin
          if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - DW_ONE;
          end else if (!r_cont && ((r_fword == r_f_stop) || (r_f_step == '0))) begin
            // A zero step can never reach stop, so a single sweep ends after one dwell.
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = STEP;
          end
        end
        STEP: begin
          w_state_nxt = DWELL;
          w_cnt_nxt   = dwell_cnt(r_dwell);
          w_pword_nxt = w_pword_step;
          if (r_fword == r_f_stop) begin
            w_fword_nxt  = r_f_start;
            w_strobe_nxt = (r_f_start != r_f_stop);
          end else begin
            w_fword_nxt  = w_nxt;
            w_strobe_nxt = w_at_stop || (r_f_step != '0);
          end
        end
        DONE: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_fword  <= '0;
      r_pword  <= '0;
      r_busy   <= 1'b0;
      r_strobe <= 1'b0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_fword  <= w_fword_nxt;
      r_pword  <= w_pword_nxt;
      r_busy   <= w_busy_nxt;
      r_strobe <= w_strobe_nxt;
      r_done   <= w_done_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign cfg_ready   = w_cfg_rdy;
  assign Fword       = r_fword;
  assign Pword       = r_pword;
  assign busy        = r_busy;
  assign step_strobe = r_strobe;
  assign sweep_done  = r_done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: per-cycle trace checked against a frequency-list model of the sweep.
module tb_dds_sweep_ctrl;

  localparam int FW = 32;
  localparam int PW = 12;
  localparam int DW = 16;
`ifdef DDS_SWEEP_PHASE_STEP_EN
  localparam bit PH_EN = 1'b1;
`else
  localparam bit PH_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [FW-1:0] cfg_f_start;
  logic [FW-1:0] cfg_f_stop;
  logic [FW-1:0] cfg_f_step;
  logic [DW-1:0] cfg_dwell;
  logic [PW-1:0] cfg_pword;
  logic          cfg_cont;
`ifdef DDS_SWEEP_PHASE_STEP_EN
  logic [PW-1:0] cfg_p_step;
`endif
  logic          start;
  logic          abort;
  logic [FW-1:0] Fword;
  logic [PW-1:0] Pword;
  logic          busy;
  logic          step_strobe;
  logic          sweep_done;

  int total = 0;
  int bad   = 0;
  longint mq[$];

  always #5 clk = ~clk;

  dds_sweep_ctrl #(.FW(FW), .PW(PW), .DW(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_f_start (cfg_f_start),
    .cfg_f_stop  (cfg_f_stop),
    .cfg_f_step  (cfg_f_step),
    .cfg_dwell   (cfg_dwell),
    .cfg_pword   (cfg_pword),
    .cfg_cont    (cfg_cont),
`ifdef DDS_SWEEP_PHASE_STEP_EN
    .cfg_p_step  (cfg_p_step),
`endif
    .start       (start),
    .abort       (abort),
    .Fword       (Fword),
    .Pword       (Pword),
    .busy        (busy),
    .step_strobe (step_strobe),
    .sweep_done  (sweep_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The list of distinct frequencies a sweep visits, in order.
  task automatic build_model(input longint fs, input longint fe, input longint st);
    longint f;
    mq.delete();
    f = fs;
    mq.push_back(f);
    while (f != fe && st != 0) begin
      if (fs <= fe) begin
        f = f + st;
        if (f > fe) f = fe;
      end else begin
        f = f - st;
        if (f < fe) f = fe;
      end
      mq.push_back(f);
    end
  endtask

  task automatic set_cfg(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                         input logic [15:0] dw, input logic [11:0] pw, input logic [11:0] ps,
                         input logic cont);
    cfg_f_start = fs;
    cfg_f_stop  = fe;
    cfg_f_step  = st;
    cfg_dwell   = dw;
    cfg_pword   = pw;
    cfg_cont    = cont;
`ifdef DDS_SWEEP_PHASE_STEP_EN
    cfg_p_step  = ps;
`else
    if (ps == 12'hFFF) cfg_pword = pw;
`endif
  endtask

  task automatic run_sweep(input logic [31:0] fs, input logic [31:0] fe, input logic [31:0] st,
                           input logic [15:0] dw, input logic [11:0] pw, input logic [11:0] ps,
                           input logic cont, input logic same, input int inj_k);
    int h, l, ncyc, idx, ns, prv, pv;
    logic [63:0] ef, ep;
    logic eb, es, ed;
    build_model(longint'(fs), longint'(fe), longint'(st));
    h = ((dw == 16'd0) ? 1 : int'(dw)) + 1;
    l = mq.size();
    ncyc = cont ? (2 * l * h + 3) : (l * h + 2);
    @(negedge clk);
    set_cfg(fs, fe, st, dw, pw, ps, cont);
    cfg_valid = 1'b1;
    start = same;
    if (!same) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("cfg_ready_idle", cfg_ready, 1);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    cfg_valid = 1'b0;
    set_cfg($urandom, $urandom, $urandom, 16'($urandom), 12'($urandom), 12'($urandom), 1'($urandom));
    for (int k = 0; k < ncyc; k++) begin
      if (cont) begin
        idx = (k % (l * h)) / h;
        ns  = k / h;
      end else begin
        idx = (k / h < l) ? (k / h) : (l - 1);
        ns  = idx;
      end
      prv = (idx == 0) ? (l - 1) : (idx - 1);
      ef = 64'(mq[idx]);
      eb = cont ? 1'b1 : (k < l * h);
      ed = !cont && (k == l * h - 1);
      es = (k == 0) || ((k % h == 0) && (cont || (k / h < l)) && (mq[idx] != mq[prv]));
      pv = int'(pw) + (PH_EN ? int'(ps) * ns : 0);
      ep = 64'(pv % 4096);
      chk($sformatf("fword k=%0d", k), Fword, ef);
      chk($sformatf("pword k=%0d", k), Pword, ep);
      chk($sformatf("busy k=%0d", k), busy, eb);
      chk($sformatf("strobe k=%0d", k), step_strobe, es);
      chk($sformatf("done k=%0d", k), sweep_done, ed);
      chk($sformatf("cfg_ready k=%0d", k), cfg_ready, !eb);
      if (k == inj_k) begin
        set_cfg(~fs, 32'd0, 32'd1, 16'd9, ~pw, 12'd1, !cont);
        cfg_valid = 1'b1;
        start = 1'b1;
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b0;
    end
    if (cont) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("cont_abort_busy", busy, 0);
      chk("cont_abort_done", sweep_done, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rfs, rfe, rspan, rst;
    int n;
    rst_n = 1'b0;
    cfg_valid = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    set_cfg(32'd0, 32'd0, 32'd0, 16'd0, 12'd0, 12'd0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_fword", Fword, 0);
    chk("rst_pword", Pword, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_strobe", step_strobe, 0);
    chk("rst_done", sweep_done, 0);
    rst_n = 1'b1;

    // Up single with a mid-sweep config/start attempt
    run_sweep(32'd262144, 32'd458752, 32'd65536, 16'd3, 12'd100, 12'd7, 1'b0, 1'b0, 6);
    // Overflow clamp to 0xFFFFFFFF
    run_sweep(32'hFFFF0000, 32'hFFFFFFFF, 32'h00010000, 16'd2, 12'd1, 12'd0, 1'b0, 1'b1, -1);
    // Down continuous
    run_sweep(32'd1048576, 32'd131072, 32'd393216, 16'd1, 12'd9, 12'd3, 1'b1, 1'b1, 3);
    // dwell=0 behaves as 1
    run_sweep(32'd100, 32'd400, 32'd100, 16'd0, 12'd5, 12'd1, 1'b0, 1'b0, 2);
    // Phase stepping wraps mod 4096
    run_sweep(32'd1000, 32'd3000, 32'd1000, 16'd1, 12'd4000, 12'd100, 1'b0, 1'b0, -1);
    // Degenerate configurations
    run_sweep(32'd777, 32'd777, 32'd5, 16'd2, 12'd3, 12'd2, 1'b0, 1'b1, -1);
    run_sweep(32'd500, 32'd900, 32'd0, 16'd2, 12'd3, 12'd2, 1'b0, 1'b1, -1);
    run_sweep(32'd777, 32'd777, 32'd5, 16'd1, 12'd3, 12'd2, 1'b1, 1'b0, -1);
    run_sweep(32'd900, 32'd500, 32'd0, 16'd1, 12'd3, 12'd2, 1'b1, 1'b0, 1);

    // Abort mid-dwell of the second frequency, then restart
    @(negedge clk);
    set_cfg(32'd1000, 32'd5000, 32'd1000, 16'd10, 12'd55, 12'd0, 1'b0);
    cfg_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    chk("abort_first", Fword, 1000);
    repeat (16) @(negedge clk);
    chk("abort_pre", Fword, 2000);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_fword", Fword, 2000);
    chk("abort_pword", Pword, 55);
    chk("abort_ready", cfg_ready, 1);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("abort_nodone i=%0d", i), sweep_done, 0);
      chk($sformatf("abort_hold i=%0d", i), Fword, 2000);
      @(negedge clk);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_fword", Fword, 1000);
    chk("restart_busy", busy, 1);
    chk("restart_strobe", step_strobe, 1);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("abort_start_busy", busy, 0);
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_start_idle", busy, 0);
    chk("abort_start_fword", Fword, 1000);
    chk("abort_start_strobe", step_strobe, 0);

    // Randomised sweeps
    for (int it = 0; it < 14; it++) begin
      rfs = $urandom;
      rfe = ($urandom_range(0, 3) == 0) ? rfs : $urandom;
      rspan = (rfs > rfe) ? (rfs - rfe) : (rfe - rfs);
      n = $urandom_range(1, 5);
      rst = rspan / n + (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 15)) : 32'd0);
      if ($urandom_range(0, 7) == 0) rst = 32'd0;
      run_sweep(rfs, rfe, rst, 16'($urandom_range(0, 3)), 12'($urandom), 12'($urandom),
                1'($urandom), 1'($urandom), 1);
    end

    // Reset mid-sweep clears outputs and config
    @(negedge clk);
    set_cfg(32'd5000, 32'd9000, 32'd1000, 16'd2, 12'd77, 12'd4, 1'b1);
    cfg_valid = 1'b1;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_fword", Fword, 0);
    chk("midrst_pword", Pword, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_strobe", step_strobe, 0);
    chk("midrst_done", sweep_done, 0);
    chk("midrst_ready", cfg_ready, 1);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cleared_fword", Fword, 0);
    chk("cleared_busy", busy, 1);
    chk("cleared_strobe", step_strobe, 1);
    @(negedge clk);
    chk("cleared_done", sweep_done, 1);
    @(negedge clk);
    chk("cleared_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
